// File: rtl/noc_link_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_link_rx_pkg
// Description : Shared NoC item geometry and the parity check used by both
//               link ends.
// Revision    : 1.0
// ============================================================================
package noc_link_rx_pkg;

    localparam int HDR_SZ  = 2;
    localparam int PL_SZ   = 32;
    localparam int ADDR_SZ = 1;
    localparam int ITEM_SZ = HDR_SZ + PL_SZ + ADDR_SZ;

    typedef logic [ITEM_SZ-1:0] item_t;
    typedef logic [ADDR_SZ-1:0] addr_t;

    // Even parity over the whole item, parity bit (MSB) included.
    function automatic logic parity_ok(input item_t item);
        return ~(^item);
    endfunction

    function automatic addr_t item_dest(input item_t item);
        return item[ADDR_SZ-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_fifo
// Description : Synchronous FIFO with count; push while full is accepted only
//               when a pop happens on the same edge.
// Revision    : 1.0
// ============================================================================
module noc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Head reads as zero while empty so the output is clean out of reset.
    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_link_rx.sv
`default_nettype none
// ============================================================================
// Module      : noc_link_rx
// Description : NoC link receiver: parity/destination screening, buffering,
//               back-pressure and sticky error reporting.
// Revision    : 1.0
// ============================================================================
module noc_link_rx
    import noc_link_rx_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CNT_SZ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_SZ-1:0] id,
    input  logic [ITEM_SZ-1:0] rx_item,
    input  logic               rx_req,
    output logic               channel_busy,
    output logic [ITEM_SZ-1:0] item_out,
    output logic               valid,
    input  logic               ni_busy,
    output logic               parity_err,
    output logic               route_err,
    output logic               ovf_err,
    output logic [CNT_SZ-1:0]  err_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_pop;
    logic              w_push;
    logic              w_bad_par;
    logic              w_bad_route;
    logic              w_ovf;
    logic              w_drop;

    logic              r_parity_err;
    logic              r_route_err;
    logic              r_ovf_err;
    logic [CNT_SZ-1:0] r_err_cnt;

    assign w_pop       = !w_empty && !ni_busy;

    // Classification priority: parity, then destination, then overflow.
    assign w_bad_par   = rx_req && !parity_ok(rx_item);
    assign w_bad_route = rx_req && parity_ok(rx_item) && (item_dest(rx_item) != id);
    assign w_ovf       = rx_req && parity_ok(rx_item) && (item_dest(rx_item) == id)
                         && w_full && !w_pop;
    assign w_push      = rx_req && parity_ok(rx_item) && (item_dest(rx_item) == id)
                         && !w_ovf;
    assign w_drop      = w_bad_par || w_bad_route || w_ovf;

    noc_fifo #(
        .W     (ITEM_SZ),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (rx_item),
        .i_pop   (w_pop),
        .o_head  (item_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign valid = !w_empty;

    // One slot of slack absorbs the upstream NI's launch latency.
    assign channel_busy = (w_count >= CW'(DEPTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
            r_route_err  <= 1'b0;
            r_ovf_err    <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            if (w_bad_par) begin
                r_parity_err <= 1'b1;
            end
            if (w_bad_route) begin
                r_route_err <= 1'b1;
            end
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end
            if (w_drop && (r_err_cnt != {CNT_SZ{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_SZ'(1);
            end
        end
    end

    assign parity_err = r_parity_err;
    assign route_err  = r_route_err;
    assign ovf_err    = r_ovf_err;
    assign err_cnt    = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_noc_link_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_link_rx
// Description : Randomized scoreboard bench for noc_link_rx.
// Revision    : 1.0
// ============================================================================
module tb_noc_link_rx;
    import noc_link_rx_pkg::*;

    localparam int    DEPTH   = 4;
    localparam int    CNT_SZ  = 8;
    localparam int    CNT_MAX = (1 << CNT_SZ) - 1;
    localparam addr_t MY_ID   = 1;

    logic               clk;
    logic               reset;
    logic [ADDR_SZ-1:0] id;
    logic [ITEM_SZ-1:0] rx_item;
    logic               rx_req;
    logic               channel_busy;
    logic [ITEM_SZ-1:0] item_out;
    logic               valid;
    logic               ni_busy;
    logic               parity_err;
    logic               route_err;
    logic               ovf_err;
    logic [CNT_SZ-1:0]  err_cnt;

    noc_link_rx #(
        .DEPTH  (DEPTH),
        .CNT_SZ (CNT_SZ)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id           (id),
        .rx_item      (rx_item),
        .rx_req       (rx_req),
        .channel_busy (channel_busy),
        .item_out     (item_out),
        .valid        (valid),
        .ni_busy      (ni_busy),
        .parity_err   (parity_err),
        .route_err    (route_err),
        .ovf_err      (ovf_err),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: expected deliveries and occupancy.
    item_t exp_q[$];
    int    m_occ  = 0;
    bit    m_perr = 1'b0;
    bit    m_rerr = 1'b0;
    bit    m_oerr = 1'b0;
    int    m_cnt  = 0;
    bit    m_pop;
    bit    m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input bit good, input addr_t dest,
                                 input logic [PL_SZ-1:0] pl, input logic [HDR_SZ-2:0] h);
        logic [ITEM_SZ-2:0] body;
        body = {h, pl, dest};
        return {(good ? ^body : ~^body), body};
    endfunction

    function automatic item_t rnd_item(input int kind);
        return mk(kind != 0, (kind == 1) ? ~MY_ID : MY_ID, $urandom, (HDR_SZ-1)'($urandom));
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_occ  = 0;
        m_perr = 1'b0;
        m_rerr = 1'b0;
        m_oerr = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Model: applies the acceptance rules at every rising edge.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_pop  = (m_occ > 0) && !ni_busy;
            m_drop = 1'b0;
            if (rx_req) begin
                if ((^rx_item) !== 1'b0) begin
                    m_perr = 1'b1;
                    m_drop = 1'b1;
                end else if (rx_item[ADDR_SZ-1:0] != id) begin
                    m_rerr = 1'b1;
                    m_drop = 1'b1;
                end else if (m_occ == DEPTH && !m_pop) begin
                    m_oerr = 1'b1;
                    m_drop = 1'b1;
                end else begin
                    exp_q.push_back(rx_item);
                    m_occ++;
                end
                if (m_drop && m_cnt < CNT_MAX) m_cnt++;
            end
            if (m_pop) m_occ--;
        end
    end

    // Monitor: checks status every cycle and consumes the expected head on pop.
    initial forever begin
        @(negedge clk);
        chk("valid", 64'(valid), 64'(m_occ != 0));
        chk("channel_busy", 64'(channel_busy), 64'(m_occ >= DEPTH - 1));
        chk("parity_err", 64'(parity_err), 64'(m_perr));
        chk("route_err", 64'(route_err), 64'(m_rerr));
        chk("ovf_err", 64'(ovf_err), 64'(m_oerr));
        chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
        if (m_occ != 0 && !ni_busy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: got pop with empty queue expected entry at %0t", $time);
            end else begin
                chk("item_out", 64'(item_out), 64'(exp_q.pop_front()));
            end
        end
    end

    item_t it;
    int    kind;

    initial begin
        reset   = 1'b0;
        rx_req  = 1'b0;
        rx_item = '0;
        ni_busy = 1'b0;
        id      = MY_ID;
        repeat (2) cyc();
        #1;
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_busy", 64'(channel_busy), 64'(0));
        chk("rst_item_out", 64'(item_out), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        reset = 1'b1;
        cyc();

        // Single item, delivered after one edge and consumed on the next.
        it = mk(1'b1, MY_ID, 32'd5, '0);
        rx_req = 1'b1; rx_item = it; ni_busy = 1'b0;
        cyc();
        rx_req = 1'b0;
        chk("single_valid", 64'(valid), 64'(1));
        chk("single_item", 64'(item_out), 64'(it));
        cyc();
        chk("single_drained", 64'(valid), 64'(0));

        // Back-pressure: fill to full with the sink stalled.
        ni_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_req = 1'b1; rx_item = rnd_item(2);
            cyc();
            if (i == 1) chk("bp_busy_after2", 64'(channel_busy), 64'(0));
            if (i == 2) chk("bp_busy_after3", 64'(channel_busy), 64'(1));
        end
        rx_req = 1'b0;
        chk("bp_no_ovf", 64'(ovf_err), 64'(0));

        // Overflow: forced push while full and stalled, then push+pop at full.
        rx_req = 1'b1; rx_item = rnd_item(2);
        cyc();
        chk("ovf_flag", 64'(ovf_err), 64'(1));
        chk("ovf_cnt", 64'(err_cnt), 64'(1));
        rx_item = rnd_item(2); ni_busy = 1'b0;
        cyc();
        rx_req = 1'b0; ni_busy = 1'b1;
        chk("full_pushpop_busy", 64'(channel_busy), 64'(1));
        chk("full_pushpop_cnt", 64'(err_cnt), 64'(1));
        ni_busy = 1'b0;
        cyc();
        chk("drain_busy_occ3", 64'(channel_busy), 64'(1));
        cyc();
        chk("drain_busy_occ2", 64'(channel_busy), 64'(0));
        repeat (3) cyc();
        chk("drain_empty", 64'(valid), 64'(0));

        // Parity and route errors.
        rx_req = 1'b1; rx_item = rnd_item(0);
        cyc();
        chk("parity_flag", 64'(parity_err), 64'(1));
        rx_item = rnd_item(1);
        cyc();
        rx_req = 1'b0;
        chk("route_flag", 64'(route_err), 64'(1));
        chk("err_cnt_after_pr", 64'(err_cnt), 64'(3));

        // Randomized traffic, mostly honouring back-pressure.
        for (int i = 0; i < 3000; i++) begin
            kind    = int'($urandom_range(0, 9));
            rx_req  = ($urandom_range(0, 99) < 60) && (!channel_busy || $urandom_range(0, 7) == 0);
            rx_item = rnd_item(kind);
            ni_busy = ($urandom_range(0, 99) < 30);
            cyc();
        end

        // Counter saturation.
        ni_busy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rx_req = 1'b1; rx_item = rnd_item(0);
            cyc();
        end
        rx_req = 1'b0;
        chk("err_cnt_saturated", 64'(err_cnt), 64'(CNT_MAX));

        // Asynchronous reset with items queued.
        ni_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_req = 1'b1; rx_item = rnd_item(2);
            cyc();
        end
        rx_req = 1'b0;
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 64'(valid), 64'(0));
        chk("arst_busy", 64'(channel_busy), 64'(0));
        chk("arst_flags", 64'({parity_err, route_err, ovf_err}), 64'(0));
        chk("arst_err_cnt", 64'(err_cnt), 64'(0));
        chk("arst_item_out", 64'(item_out), 64'(0));
        cyc();
        reset = 1'b1;
        ni_busy = 1'b0;
        it = rnd_item(2);
        rx_req = 1'b1; rx_item = it;
        cyc();
        rx_req = 1'b0;
        chk("post_rst_valid", 64'(valid), 64'(1));
        chk("post_rst_item", 64'(item_out), 64'(it));
        cyc();
        chk("post_rst_drained", 64'(valid), 64'(0));
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
